// File: rtl/sonar_pkg.sv
// ---------------------------------------------------------------------------
// sonar_pkg
// Shared definitions for the HC-SR04-style echo emulator and for any
// scoreboard that needs the same echo-width arithmetic.
//   US_PER_CM_X100     : round-trip microseconds per cm, scaled by 100
//   DIST_MIN_CM        : distances below this are clamped up to it
//   DIST_MAX_CM        : distances above this behave as "no object"
//   TIMEOUT_US_DEFAULT : echo width used when there is no return
//   state_t            : emulator FSM states
//   calc_largura_us    : echo width in us for a distance / object flag
// ---------------------------------------------------------------------------
package sonar_pkg;

  localparam int US_PER_CM_X100     = 5882;
  localparam int DIST_MIN_CM        = 2;
  localparam int DIST_MAX_CM        = 400;
  localparam int TIMEOUT_US_DEFAULT = 38000;

  typedef enum logic [2:0] {
    IDLE,
    TRIG_HIGH,
    DELAY,
    ECHO,
    HOLDOFF
  } state_t;

  // Width rounds to nearest: (d * 5882 + 50) / 100. The worst case
  // 400 * 5882 + 50 still fits the 22-bit product, and the quotient
  // (at most 23528) fits 16 bits.
  function automatic logic [15:0] calc_largura_us(
    input logic [8:0]  distancia,
    input logic        objeto,
    input logic [15:0] timeout_us = 16'(TIMEOUT_US_DEFAULT)
  );
    logic [8:0]  distEf;
    logic [21:0] produto;
    logic [15:0] largura;
    distEf  = distancia;
    produto = '0;
    largura = timeout_us;
    if (objeto && (distancia <= 9'(DIST_MAX_CM))) begin
      if (distancia < 9'(DIST_MIN_CM)) begin
        distEf = 9'(DIST_MIN_CM);
      end
      produto = 22'(distEf) * 22'(US_PER_CM_X100) + 22'd50;
      largura = 16'(produto / 22'd100);
    end
    return largura;
  endfunction

endpackage

// File: rtl/sonar_echo_emulator_contador_us.sv
// ---------------------------------------------------------------------------
// contador_us
// Microsecond time base: a prescaler that wraps every CLK_PER_US cycles and
// a saturating 16-bit microsecond counter.
//   clock    : system clock
//   reset    : asynchronous, active-low
//   i_clear  : synchronous clear of prescaler and counter (state entry)
//   i_target : duration in us for the done compare
//   o_count  : microseconds elapsed since the last clear
//   o_done   : high on the last cycle of a period of i_target us, so the
//              owner can change state on exactly the i_target-th us boundary
// ---------------------------------------------------------------------------
module contador_us #(
  parameter int CLK_PER_US = 50
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_clear,
  input  logic [15:0] i_target,
  output logic [15:0] o_count,
  output logic        o_done
);

  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_US - 1);

  logic [PW-1:0] r_presc;
  logic [15:0]   r_count;
  logic          w_tick;

  assign w_tick  = (r_presc == PRESC_LAST);
  assign o_count = r_count;
  assign o_done  = w_tick && (r_count == (i_target - 16'd1));

  // Counter saturates instead of wrapping so that a very long trigger is
  // still seen as long enough.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_presc <= '0;
      r_count <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      if (r_count != 16'hFFFF) begin
        r_count <= r_count + 16'd1;
      end
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

endmodule

// File: rtl/sonar_echo_emulator.sv
// ---------------------------------------------------------------------------
// sonar_echo_emulator
// Responder side of one HC-SR04-style ultrasonic sensor: accepts a trigger
// pulse, waits the acoustic delay, then drives echo for a width proportional
// to the programmed distance, followed by a hold-off period.
//   clock        : system clock (CLK_PER_US cycles per us)
//   reset        : asynchronous, active-low
//   trigger      : trigger from the sonar controller (asynchronous)
//   distancia    : programmed distance in cm
//   objeto       : 1 = object present, 0 = no return (timeout width)
//   echo         : registered echo pulse
//   ocupado      : 1 whenever the emulator is not idle
//   erro_trigger : one-cycle pulse when a too-short trigger is rejected
// ---------------------------------------------------------------------------
module sonar_echo_emulator
  import sonar_pkg::*;
#(
  parameter int CLK_PER_US  = 50,
  parameter int TRIG_MIN_US = 10,
  parameter int DELAY_US    = 400,
  parameter int TIMEOUT_US  = 38000,
  parameter int HOLDOFF_US  = 60000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger,
  input  logic [8:0] distancia,
  input  logic       objeto,
  output logic       echo,
  output logic       ocupado,
  output logic       erro_trigger
);

  localparam logic [15:0] TRIG_MIN_T = 16'(TRIG_MIN_US);
  localparam logic [15:0] DELAY_T    = 16'(DELAY_US);
  localparam logic [15:0] TIMEOUT_T  = 16'(TIMEOUT_US);
  localparam logic [15:0] HOLDOFF_T  = 16'(HOLDOFF_US);

  state_t      r_state;
  state_t      w_nextState;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_trigPrev;
  logic [15:0] r_largura;
  logic        r_echo;
  logic        r_ocupado;
  logic        r_erro;

  logic        w_trigRise;
  logic        w_trigFall;
  logic        w_trigOk;
  logic        w_accept;
  logic        w_cntClear;
  logic [15:0] w_cntTarget;
  logic [15:0] w_usCount;
  logic        w_cntDone;
  logic        w_echoNext;
  logic        w_ocupadoNext;
  logic        w_erroNext;

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_trigPrev <= 1'b0;
    end else begin
      r_sync1    <= trigger;
      r_sync2    <= r_sync1;
      r_trigPrev <= r_sync2;
    end
  end

  assign w_trigRise = r_sync2 & ~r_trigPrev;
  assign w_trigFall = ~r_sync2 & r_trigPrev;
  assign w_trigOk   = (w_usCount >= TRIG_MIN_T);
  assign w_accept   = (r_state == TRIG_HIGH) && w_trigFall && w_trigOk;

  // The counter is held clear in IDLE but already runs on the rise-detect
  // cycle, so the trigger width includes every cycle trig_s was high.
  // Elsewhere it restarts on every state change.
  always_comb begin
    w_cntClear = (r_state != w_nextState);
    if (r_state == IDLE) begin
      w_cntClear = ~w_trigRise;
    end
  end

  always_comb begin
    w_cntTarget = 16'hFFFF;
    case (r_state)
      DELAY:   w_cntTarget = DELAY_T;
      ECHO:    w_cntTarget = r_largura;
      HOLDOFF: w_cntTarget = HOLDOFF_T;
      default: w_cntTarget = 16'hFFFF;
    endcase
  end

  contador_us #(
    .CLK_PER_US (CLK_PER_US)
  ) u_contador (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_cntClear),
    .i_target (w_cntTarget),
    .o_count  (w_usCount),
    .o_done   (w_cntDone)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; trigger edges are only looked at in IDLE/TRIG_HIGH.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_trigRise) w_nextState = TRIG_HIGH;
      end
      TRIG_HIGH: begin
        if (w_trigFall) w_nextState = w_trigOk ? DELAY : IDLE;
      end
      DELAY: begin
        if (w_cntDone) w_nextState = ECHO;
      end
      ECHO: begin
        if (w_cntDone) w_nextState = HOLDOFF;
      end
      HOLDOFF: begin
        if (w_cntDone) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Output values are decoded from the next state so that the registered
  // outputs change on the same edge as the state itself.
  always_comb begin
    w_echoNext    = (w_nextState == ECHO);
    w_ocupadoNext = (w_nextState != IDLE);
    w_erroNext    = (r_state == TRIG_HIGH) && w_trigFall && !w_trigOk;
  end

  // Output registers and the echo width latched once at acceptance.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_echo    <= 1'b0;
      r_ocupado <= 1'b0;
      r_erro    <= 1'b0;
      r_largura <= '0;
    end else begin
      r_echo    <= w_echoNext;
      r_ocupado <= w_ocupadoNext;
      r_erro    <= w_erroNext;
      if (w_accept) begin
        r_largura <= calc_largura_us(distancia, objeto, TIMEOUT_T);
      end
    end
  end

  assign echo         = r_echo;
  assign ocupado      = r_ocupado;
  assign erro_trigger = r_erro;

endmodule

// File: tb/tb_sonar_echo_emulator.sv
// ---------------------------------------------------------------------------
// tb_sonar_echo_emulator
// Directed bench for sonar_echo_emulator. Time constants are scaled down
// (2 cycles per us, shorter timeout and hold-off) so whole transactions fit
// a short run; distance-derived widths keep their real microsecond values.
// ---------------------------------------------------------------------------
module tb_sonar_echo_emulator;

  localparam int CPU     = 2;
  localparam int TMIN    = 10;
  localparam int DLY     = 400;
  localparam int TMO     = 1000;
  localparam int HOLD    = 600;
  localparam int LIMIT   = 30000;
  localparam int TRIG_OK = TMIN * CPU;

  // Rise is seen DLY*CPU cycles after the state leaves TRIG_HIGH, which
  // itself is 3 edges after the trigger input falls (2 sync + detect).
  localparam int EXP_DELAY = DLY * CPU + 3;
  localparam int EXP_HOLD  = HOLD * CPU;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       trigger = 1'b0;
  logic [8:0] distancia = 9'd100;
  logic       objeto = 1'b1;
  logic       echo;
  logic       ocupado;
  logic       erro_trigger;

  int errors = 0;
  int checks = 0;

  sonar_echo_emulator #(
    .CLK_PER_US  (CPU),
    .TRIG_MIN_US (TMIN),
    .DELAY_US    (DLY),
    .TIMEOUT_US  (TMO),
    .HOLDOFF_US  (HOLD)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .trigger      (trigger),
    .distancia    (distancia),
    .objeto       (objeto),
    .echo         (echo),
    .ocupado      (ocupado),
    .erro_trigger (erro_trigger)
  );

  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Raises trigger for exactly cyclesHigh cycles, returning just after the fall.
  task automatic applyStimulus(input int cyclesHigh);
    @(negedge clock);
    trigger = 1'b1;
    repeat (cyclesHigh) @(negedge clock);
    trigger = 1'b0;
  endtask

  // Follows one accepted transaction from the trigger fall: cycles to echo
  // rise, echo width, ocupado at echo fall, and hold-off length. Optionally
  // changes distancia during the delay and re-triggers in ECHO / HOLDOFF.
  task automatic runEcho(input int changeAt, input logic [8:0] newDist,
                         input int retrigEcho, input int retrigHold,
                         output int delayC, output int widthC,
                         output int holdC, output int busyAtFall);
    int cnt;
    delayC = -1; widthC = -1; holdC = -1; busyAtFall = -1;
    cnt = 0;
    while (cnt < LIMIT) begin
      @(posedge clock); #1;
      cnt++;
      if (cnt == changeAt) distancia = newDist;
      if (echo) break;
    end
    if (!echo) return;
    delayC = cnt;
    cnt = 0;
    while (echo && cnt < LIMIT) begin
      @(posedge clock); #1;
      cnt++;
      if (retrigEcho != 0) begin
        if (cnt == retrigEcho) trigger = 1'b1;
        if (cnt == retrigEcho + TRIG_OK) trigger = 1'b0;
      end
    end
    if (echo) return;
    widthC = cnt;
    busyAtFall = int'(ocupado);
    cnt = 0;
    while (ocupado && cnt < LIMIT) begin
      @(posedge clock); #1;
      cnt++;
      if (retrigHold != 0) begin
        if (cnt == retrigHold) trigger = 1'b1;
        if (cnt == retrigHold + TRIG_OK) trigger = 1'b0;
      end
    end
    if (!ocupado) holdC = cnt;
  endtask

  int dC, wC, hC, bF;
  int errCnt, busyAtErr, echoCnt, busyCnt;

  initial begin
    $display("[TB] start");

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_echo", int'(echo), 0);
    checkOutput("reset_ocupado", int'(ocupado), 0);
    checkOutput("reset_erro", int'(erro_trigger), 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // 100 cm, 10 us trigger: 5882 us echo.
    distancia = 9'd100; objeto = 1'b1;
    applyStimulus(TRIG_OK);
    runEcho(0, 9'd0, 0, 0, dC, wC, hC, bF);
    checkOutput("d100_delay", dC, EXP_DELAY);
    checkOutput("d100_width", wC, 5882 * CPU);
    checkOutput("d100_busy_at_fall", bF, 1);
    checkOutput("d100_holdoff", hC, EXP_HOLD);

    // 74 cm rounds 4352.68 up to 4353 us.
    distancia = 9'd74;
    applyStimulus(TRIG_OK);
    runEcho(0, 9'd0, 0, 0, dC, wC, hC, bF);
    checkOutput("d74_width", wC, 4353 * CPU);

    // 1 cm clamps to 2 cm: 118 us.
    distancia = 9'd1;
    applyStimulus(TRIG_OK);
    runEcho(0, 9'd0, 0, 0, dC, wC, hC, bF);
    checkOutput("d1_width", wC, 118 * CPU);

    // 401 cm is out of range: timeout width.
    distancia = 9'd401;
    applyStimulus(TRIG_OK);
    runEcho(0, 9'd0, 0, 0, dC, wC, hC, bF);
    checkOutput("d401_width", wC, TMO * CPU);

    // Short trigger rejected: one erro pulse, ocupado drops with it.
    distancia = 9'd100;
    applyStimulus(5 * CPU);
    errCnt = 0; busyAtErr = -1; echoCnt = 0;
    repeat (12) begin
      @(posedge clock); #1;
      if (erro_trigger) begin
        errCnt++;
        busyAtErr = int'(ocupado);
      end
    end
    repeat (1000) begin
      @(posedge clock); #1;
      if (echo) echoCnt++;
    end
    checkOutput("short_erro_pulses", errCnt, 1);
    checkOutput("short_busy_at_erro", busyAtErr, 0);
    checkOutput("short_echo_cycles", echoCnt, 0);

    // No object, with re-triggers in ECHO and HOLDOFF that must be ignored.
    objeto = 1'b0;
    applyStimulus(TRIG_OK);
    runEcho(0, 9'd0, 100, 100, dC, wC, hC, bF);
    checkOutput("noobj_width", wC, TMO * CPU);
    checkOutput("noobj_holdoff", hC, EXP_HOLD);
    echoCnt = 0; busyCnt = 0;
    repeat (2000) begin
      @(posedge clock); #1;
      if (echo) echoCnt++;
      if (ocupado) busyCnt++;
    end
    checkOutput("retrig_echo_cycles", echoCnt, 0);
    checkOutput("retrig_busy_cycles", busyCnt, 0);

    // Distance change during DELAY does not affect the latched width.
    objeto = 1'b1;
    distancia = 9'd100;
    applyStimulus(TRIG_OK);
    runEcho(100, 9'd50, 0, 0, dC, wC, hC, bF);
    checkOutput("dchange_delay", dC, EXP_DELAY);
    checkOutput("dchange_width", wC, 5882 * CPU);

    // Reset mid-ECHO drops echo at once; a new trigger right after
    // release is accepted.
    distancia = 9'd20;
    applyStimulus(TRIG_OK);
    echoCnt = 0;
    while (!echo && echoCnt < LIMIT) begin
      @(posedge clock); #1;
      echoCnt++;
    end
    checkOutput("rst_echo_started", int'(echo), 1);
    repeat (50) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("rst_echo_dropped", int'(echo), 0);
    checkOutput("rst_busy_dropped", int'(ocupado), 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    applyStimulus(TRIG_OK);
    runEcho(0, 9'd0, 0, 0, dC, wC, hC, bF);
    checkOutput("after_rst_delay", dC, EXP_DELAY);
    checkOutput("after_rst_width", wC, 1176 * CPU);
    checkOutput("after_rst_holdoff", hC, EXP_HOLD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
